// File: rtl/pe_packet_receiver.sv
// rtl/pe_packet_receiver.sv - NoC receive endpoint: destination filter, type decode, payload FIFO
//
// Purpose: accepts 34-bit NoC packets from a router output port, keeps those addressed to
// MY_ADDR with a non-zero type, and queues {src,type,data} for the attached PE. Counts ifmap
// (type 10) packets and raises frame_done after N_EXPECT of them, back-pressuring the router
// until frame_clr. Counts dropped packets in a saturating drop_cnt.
// Packet layout: [33:30] dest, [29:26] src, [25:24] type, [23:8] reserved, [7:0] data.
//
// Ports:
//   clk, rst              rising-edge clock, synchronous active-high reset
//   in_valid/in_ready     packet handshake from the router, in_pkt carries the packet
//   out_valid/out_ready   FIFO head handshake to the PE; out_data/out_type/out_src describe the head
//   frame_done            N_EXPECT ifmap packets received; held until frame_clr
//   frame_clr             one-cycle pulse clearing frame_done and the ifmap count
//   drop_cnt              saturating count of dropped packets
//
// Build option: define PKT_RSVD_CHECK_EN to drop packets whose reserved bits [23:8] are non-zero.
module pe_packet_receiver #(
  parameter logic [3:0] MY_ADDR  = 4'b1000,
  parameter int         DEPTH    = 4,
  parameter int         N_EXPECT = 3,
  parameter int         CNT_W    = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [33:0]      in_pkt,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [7:0]       out_data,
  output logic [1:0]       out_type,
  output logic [3:0]       out_src,
  output logic             frame_done,
  input  logic             frame_clr,
  output logic [CNT_W-1:0] drop_cnt
);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int IW = $clog2(N_EXPECT + 1);
  localparam logic [PW:0]   FULL_CNT   = (PW + 1)'(DEPTH);
  localparam logic [IW-1:0] LAST_IFM   = IW'(N_EXPECT);
  localparam logic [1:0]    TYPE_IFMAP = 2'b10;

  typedef enum logic [1:0] {IDLE, RECV, DONE} state_t;

  state_t           state_q;
  logic [13:0]      mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [PW:0]      count_q, count_d;
  logic [IW-1:0]    ifm_cnt_q;
  logic [IW-1:0]    ifm_next;
  logic             out_valid_q;
  logic [7:0]       out_data_q;
  logic [1:0]       out_type_q;
  logic [3:0]       out_src_q;
  logic             frame_done_q;
  logic [CNT_W-1:0] drop_cnt_q;

  logic [3:0]  pkt_dest;
  logic [3:0]  pkt_src;
  logic [1:0]  pkt_type;
  logic [7:0]  pkt_data;
  logic        rsvd_bad;
  logic        fifo_full;
  logic        accept;
  logic        keep;
  logic        push;
  logic        drop;
  logic        pop;
  logic        is_ifmap;
  logic        ifm_last;
  logic [13:0] wr_entry;
  logic [13:0] head_d;

  assign pkt_dest = in_pkt[33:30];
  assign pkt_src  = in_pkt[29:26];
  assign pkt_type = in_pkt[25:24];
  assign pkt_data = in_pkt[7:0];

`ifdef PKT_RSVD_CHECK_EN
  assign rsvd_bad = |in_pkt[23:8];
`else
  logic unused_rsvd;
  assign unused_rsvd = ^in_pkt[23:8];
  assign rsvd_bad    = 1'b0;
`endif

  // Dropped packets are consumed through the same ready as kept ones, so a full FIFO
  // stalls everything uniformly.
  assign fifo_full = (count_q == FULL_CNT);
  assign in_ready  = (state_q == RECV) && !fifo_full;
  assign accept    = in_valid && in_ready;
  assign keep      = (pkt_dest == MY_ADDR) && (pkt_type != 2'b00) && !rsvd_bad;
  assign push      = accept && keep;
  assign drop      = accept && !keep;
  assign pop       = out_valid_q && out_ready;
  assign wr_entry  = {pkt_src, pkt_type, pkt_data};
  assign is_ifmap  = push && (pkt_type == TYPE_IFMAP);
  assign ifm_next  = ifm_cnt_q + 1'b1;
  assign ifm_last  = is_ifmap && (ifm_next == LAST_IFM);

  always_comb begin
    wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
    count_d  = count_q;
    if (push && !pop) begin
      count_d = count_q + 1'b1;
    end else if (!push && pop) begin
      count_d = count_q - 1'b1;
    end
    // The entry being written this cycle becomes the head only when it lands in the
    // slot the read pointer is about to point at (i.e. it is the sole entry).
    if (push && (wr_ptr_q == rd_ptr_d)) begin
      head_d = wr_entry;
    end else begin
      head_d = mem_q[rd_ptr_d];
    end
  end

  // Storage needs no reset: pointers and occupancy are cleared, so old contents are unreachable.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= wr_entry;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      ifm_cnt_q    <= '0;
      out_valid_q  <= 1'b0;
      out_data_q   <= '0;
      out_type_q   <= '0;
      out_src_q    <= '0;
      frame_done_q <= 1'b0;
      drop_cnt_q   <= '0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      out_valid_q <= (count_d != '0);
      // Head registers only change when there is a head; when empty they keep the last value.
      if (count_d != '0) begin
        {out_src_q, out_type_q, out_data_q} <= head_d;
      end

      if (drop && (drop_cnt_q != '1)) begin
        drop_cnt_q <= drop_cnt_q + 1'b1;
      end

      if (frame_clr) begin
        ifm_cnt_q <= '0;
      end else if (is_ifmap) begin
        ifm_cnt_q <= ifm_next;
      end

      case (state_q)
        IDLE: state_q <= RECV;
        RECV: begin
          // A clear in the same cycle as the final ifmap cancels the frame completion.
          if (ifm_last && !frame_clr) begin
            state_q      <= DONE;
            frame_done_q <= 1'b1;
          end
        end
        DONE: begin
          if (frame_clr) begin
            state_q      <= RECV;
            frame_done_q <= 1'b0;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign out_valid  = out_valid_q;
  assign out_data   = out_data_q;
  assign out_type   = out_type_q;
  assign out_src    = out_src_q;
  assign frame_done = frame_done_q;
  assign drop_cnt   = drop_cnt_q;

endmodule
